// File: rtl/axis_peak_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// axis_peak_meter : AXI-Stream stereo register slice with decaying peak meters,
//                   4-LED thermometer bars and held clip indicators.
// Revision 1.0
// ============================================================================
module axis_peak_meter #(
  parameter int DATA_WIDTH       = 24,
  parameter int DECAY_FRAMES     = 1024,
  parameter int CLIP_HOLD_FRAMES = 24000
) (
  input  logic                  axis_clk,
  input  logic                  axis_resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [3:0]            led_l,
  output logic [3:0]            led_r,
  output logic                  clip_l,
  output logic                  clip_r
);

  localparam int FW = $clog2(DECAY_FRAMES);
  localparam int HW = $clog2(CLIP_HOLD_FRAMES + 1);

  localparam logic [DATA_WIDTH-1:0] MAG_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] TH0 = DATA_WIDTH'(32'h0000_0800);
  localparam logic [DATA_WIDTH-1:0] TH1 = DATA_WIDTH'(32'h0000_8000);
  localparam logic [DATA_WIDTH-1:0] TH2 = DATA_WIDTH'(32'h0008_0000);
  localparam logic [DATA_WIDTH-1:0] TH3 = DATA_WIDTH'(32'h0040_0000);
  localparam logic [FW-1:0]         FRAME_LAST = FW'(DECAY_FRAMES - 1);
  localparam logic [HW-1:0]         HOLD_LOAD  = HW'(CLIP_HOLD_FRAMES);

  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] peak_l_q, peak_l_d;
  logic [DATA_WIDTH-1:0] peak_r_q, peak_r_d;
  logic [3:0]            led_l_q, led_l_d;
  logic [3:0]            led_r_q, led_r_d;
  logic                  clip_l_q, clip_l_d;
  logic                  clip_r_q, clip_r_d;
  logic [HW-1:0]         hold_l_q, hold_l_d;
  logic [HW-1:0]         hold_r_q, hold_r_d;
  logic [FW-1:0]         frame_q, frame_d;

  logic                  accept;
  logic                  frame_end;
  logic                  decay_tick;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] base_l;
  logic [DATA_WIDTH-1:0] base_r;
  logic                  hit_l;
  logic                  hit_r;

  function automatic logic [3:0] thermo(input logic [DATA_WIDTH-1:0] p);
    thermo = {p >= TH3, p >= TH2, p >= TH1, p >= TH0};
  endfunction

  assign s_axis_ready = axis_resetn && (!m_valid_q || m_axis_ready);
  assign accept       = s_axis_valid && s_axis_ready;
  assign frame_end    = accept && s_axis_last;
  assign decay_tick   = frame_end && (frame_q == FRAME_LAST);
  assign hit_l        = accept && !s_axis_last && (mag == MAG_MAX);
  assign hit_r        = accept &&  s_axis_last && (mag == MAG_MAX);

  always_comb begin
    mag = s_axis_data;
    if (s_axis_data == MOST_NEG) begin
      mag = MAG_MAX;
    end else if (s_axis_data[DATA_WIDTH-1]) begin
      mag = -s_axis_data;
    end
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (accept) begin
      m_data_d  = s_axis_data;
      m_last_d  = s_axis_last;
      m_valid_d = 1'b1;
    end else if (m_axis_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Decay is folded in ahead of the max so a tick beat can still raise the peak.
  always_comb begin
    base_l   = decay_tick ? (peak_l_q - (peak_l_q >> 3)) : peak_l_q;
    base_r   = decay_tick ? (peak_r_q - (peak_r_q >> 3)) : peak_r_q;
    peak_l_d = base_l;
    peak_r_d = base_r;
    if (accept && !s_axis_last && (mag > base_l)) begin
      peak_l_d = mag;
    end
    if (accept && s_axis_last && (mag > base_r)) begin
      peak_r_d = mag;
    end
    led_l_d = thermo(peak_l_q);
    led_r_d = thermo(peak_r_q);
  end

  always_comb begin
    frame_d = frame_q;
    if (frame_end) begin
      frame_d = decay_tick ? '0 : frame_q + FW'(1);
    end
    hold_l_d = hold_l_q;
    if (hit_l) begin
      hold_l_d = HOLD_LOAD;
    end else if (frame_end && (hold_l_q != '0)) begin
      hold_l_d = hold_l_q - HW'(1);
    end
    hold_r_d = hold_r_q;
    if (hit_r) begin
      hold_r_d = HOLD_LOAD;
    end else if (frame_end && (hold_r_q != '0)) begin
      hold_r_d = hold_r_q - HW'(1);
    end
    // Flag follows the counter one cycle late so it drops the cycle after zero.
    clip_l_d = hit_l || (hold_l_q != '0);
    clip_r_d = hit_r || (hold_r_q != '0);
  end

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      peak_l_q  <= '0;
      peak_r_q  <= '0;
      led_l_q   <= '0;
      led_r_q   <= '0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      frame_q   <= '0;
    end else begin
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      peak_l_q  <= peak_l_d;
      peak_r_q  <= peak_r_d;
      led_l_q   <= led_l_d;
      led_r_q   <= led_r_d;
      clip_l_q  <= clip_l_d;
      clip_r_q  <= clip_r_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      frame_q   <= frame_d;
    end
  end

  assign m_axis_data  = m_data_q;
  assign m_axis_last  = m_last_q;
  assign m_axis_valid = m_valid_q;
  assign led_l        = led_l_q;
  assign led_r        = led_r_q;
  assign clip_l       = clip_l_q;
  assign clip_r       = clip_r_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_peak_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_axis_peak_meter : directed self-checking bench for axis_peak_meter
//                      (DECAY_FRAMES=2, CLIP_HOLD_FRAMES=4).
// Revision 1.0
// ============================================================================
module tb_axis_peak_meter;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [3:0]    led_l;
  logic [3:0]    led_r;
  logic          clip_l;
  logic          clip_r;

  int n_checks = 0;
  int n_err    = 0;

  axis_peak_meter #(
    .DATA_WIDTH      (DW),
    .DECAY_FRAMES    (2),
    .CLIP_HOLD_FRAMES(4)
  ) dut (
    .axis_clk    (clk),
    .axis_resetn (rstn),
    .s_axis_data (s_data),
    .s_axis_valid(s_valid),
    .s_axis_ready(s_ready),
    .s_axis_last (s_last),
    .m_axis_data (m_data),
    .m_axis_valid(m_valid),
    .m_axis_ready(m_ready),
    .m_axis_last (m_last),
    .led_l       (led_l),
    .led_r       (led_r),
    .clip_l      (clip_l),
    .clip_r      (clip_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat from a falling edge; returns on the following falling edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] tbl [8];
    tbl = '{24'h000001, 24'h0007FF, 24'hFFF801, 24'h000123,
            24'h000456, 24'hFFFFFF, 24'h000000, 24'h000700};

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data",  32'(m_data),  32'h0);
    chk("rst_m_last",  32'(m_last),  32'h0);
    chk("rst_led_l",   32'(led_l),   32'h0);
    chk("rst_led_r",   32'(led_r),   32'h0);
    chk("rst_clip_l",  32'(clip_l),  32'h0);
    chk("rst_clip_r",  32'(clip_r),  32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    rstn = 1'b1;
    #1;
    chk("rel_s_ready", 32'(s_ready), 32'h1);

    // Full-throughput pass-through, one output per cycle.
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("thru_valid", 32'(m_valid), 32'h1);
        chk("thru_data",  32'(m_data),  32'(tbl[i-1]));
        chk("thru_last",  32'(m_last),  32'((i - 1) % 2));
        chk("thru_ready", 32'(s_ready), 32'h1);
      end
      if (i < 8) begin
        s_data  = tbl[i];
        s_last  = 1'((i % 2));
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("thru_drain_valid", 32'(m_valid), 32'h0);
    chk("below_th_led_l",   32'(led_l),   32'h0);
    chk("below_th_led_r",   32'(led_r),   32'h0);

    // Basic magnitude / thermometer mapping.
    send(24'h100000, 1'b0);
    send(24'hFFF000, 1'b1);
    idle();
    chk("mag_peak_l", 32'(dut.peak_l_q), 32'h100000);
    chk("mag_peak_r", 32'(dut.peak_r_q), 32'h001000);
    chk("mag_led_l",  32'(led_l),        32'h7);
    chk("mag_led_r",  32'(led_r),        32'h1);

    // Backpressure: output holds, nothing accepted while stalled.
    m_ready = 1'b0;
    s_data  = 24'h123456;
    s_last  = 1'b0;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_data = 24'h000100;
    s_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(m_valid), 32'h1);
      chk("stall_data",  32'(m_data),  32'h123456);
      chk("stall_ready", 32'(s_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    m_ready = 1'b1;
    #1;
    chk("release_ready", 32'(s_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("release_data",  32'(m_data),  32'h000100);
    chk("release_last",  32'(m_last),  32'h1);
    chk("release_valid", 32'(m_valid), 32'h1);
    idle();
    // The released right word was the decay tick.
    chk("tick_peak_l", 32'(dut.peak_l_q), 32'h0FEDCC);
    chk("tick_peak_r", 32'(dut.peak_r_q), 32'h000E00);
    chk("tick_led_l",  32'(led_l),        32'h7);
    chk("tick_led_r",  32'(led_r),        32'h1);

    // Left clip with a retrigger at frame 3.
    send(24'h800000, 1'b0);
    send(24'h000000, 1'b1);
    chk("clip_l_set",  32'(clip_l),        32'h1);
    chk("clip_led_l",  32'(led_l),         32'hF);
    chk("clip_peak_l", 32'(dut.peak_l_q),  32'h7FFFFF);
    send(24'h000000, 1'b0);
    send(24'h000000, 1'b1);
    send(24'h800000, 1'b0);
    send(24'h000000, 1'b1);
    send(24'h000000, 1'b0);
    send(24'h000000, 1'b1);
    idle();
    chk("clip_l_extended", 32'(clip_l), 32'h1);
    send(24'h000000, 1'b0);
    send(24'h000000, 1'b1);
    send(24'h000000, 1'b0);
    send(24'h000000, 1'b1);
    chk("clip_l_last_frame", 32'(clip_l), 32'h1);
    idle();
    chk("clip_l_cleared", 32'(clip_l), 32'h0);

    // Right clip on the frame word itself: reload beats the decrement.
    send(24'h000000, 1'b0);
    send(24'h800001, 1'b1);
    chk("clip_r_set", 32'(clip_r), 32'h1);
    for (int k = 0; k < 3; k++) begin
      send(24'h000000, 1'b0);
      send(24'h000000, 1'b1);
    end
    idle();
    chk("clip_r_held", 32'(clip_r), 32'h1);
    send(24'h000000, 1'b0);
    send(24'h000000, 1'b1);
    chk("clip_r_last_frame", 32'(clip_r), 32'h1);
    idle();
    chk("clip_r_cleared", 32'(clip_r), 32'h0);
    chk("clip_l_stays_off", 32'(clip_l), 32'h0);

    // Asynchronous reset with a stalled beat in the output register.
    m_ready = 1'b0;
    send(24'h7FFFFF, 1'b0);
    chk("pre_rst_valid",  32'(m_valid), 32'h1);
    chk("pre_rst_clip_l", 32'(clip_l),  32'h1);
    s_data  = 24'h000055;
    s_last  = 1'b1;
    s_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid",  32'(m_valid),       32'h0);
    chk("arst_led_l",  32'(led_l),         32'h0);
    chk("arst_led_r",  32'(led_r),         32'h0);
    chk("arst_clip_l", 32'(clip_l),        32'h0);
    chk("arst_clip_r", 32'(clip_r),        32'h0);
    chk("arst_ready",  32'(s_ready),       32'h0);
    chk("arst_peak_l", 32'(dut.peak_l_q),  32'h0);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    rstn    = 1'b1;
    #1;
    chk("arst_release_ready", 32'(s_ready), 32'h1);

    // Decay every second frame; tick beat on the right takes max after decay.
    send(24'h400000, 1'b0);
    send(24'h000000, 1'b1);
    chk("decay_led_l_full", 32'(led_l), 32'hF);
    send(24'h000000, 1'b0);
    send(24'h000000, 1'b1);
    chk("decay1_peak_l", 32'(dut.peak_l_q), 32'h380000);
    idle();
    chk("decay1_led_l", 32'(led_l), 32'h7);
    send(24'h000000, 1'b0);
    send(24'h400000, 1'b1);
    send(24'h000000, 1'b0);
    send(24'h390000, 1'b1);
    chk("decay2_peak_l", 32'(dut.peak_l_q), 32'h310000);
    chk("decay2_peak_r", 32'(dut.peak_r_q), 32'h390000);
    idle();
    chk("decay2_led_l", 32'(led_l), 32'h7);
    chk("decay2_led_r", 32'(led_r), 32'h7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_peak_meter.md
Name: axis_peak_meter

Overview:
- AXI-Stream pass-through stage between the volume controller output and the I2S2 transmit input.
- Forwards 24-bit stereo samples unchanged with one register of latency.
- Tracks a per-channel decaying peak magnitude and drives 4-LED thermometer bar graphs plus clip indicators.
- Stream framing: the left word carries last=0 and the right word carries last=1.

Parameters:
DATA_WIDTH, 24, sample width (two's complement); thresholds below assume 24
DECAY_FRAMES, 1024, accepted stereo frames between decay ticks (>=2)
CLIP_HOLD_FRAMES, 24000, frames a clip flag stays high after the last clipping sample (>=1)

Ports:
axis_clk  in  1  stream clock; all logic on rising edge
axis_resetn  in  1  asynchronous active-low reset
s_axis_data  in  DATA_WIDTH  input sample
s_axis_valid  in  1  input valid
s_axis_ready  out  1  input ready
s_axis_last  in  1  1 = right channel word
m_axis_data  out  DATA_WIDTH  output sample (bit-identical to input)
m_axis_valid  out  1  output valid
m_axis_ready  in  1  downstream ready
m_axis_last  out  1  forwarded last
led_l  out  4  left-channel thermometer bar
led_r  out  4  right-channel thermometer bar
clip_l  out  1  left clip indicator
clip_r  out  1  right clip indicator

Behaviour:
- Reset (async assert, sync release): m_axis_valid=0, m_axis_data=0, m_axis_last=0, led_l=led_r=0, clip_l=clip_r=0; peaks, frame counter and clip counters all 0. s_axis_ready=0 while axis_resetn is low.
- Register slice:
  - s_axis_ready = !m_axis_valid || m_axis_ready (combinational, gated by reset).
  - Accept when s_axis_valid && s_axis_ready: data and last load into the output register and m_axis_valid=1 the next cycle.
  - If not accepting and m_axis_ready=1, m_axis_valid clears.
  - Full throughput (one beat per cycle) when downstream is always ready.
  - m_axis_data and m_axis_last stay stable while valid && !ready.
- Magnitude: computed on accepted beats only.
  - mag = |sample|; the most negative value (0x800000) saturates to 0x7FFFFF.
  - Channel is selected by s_axis_last.
- Peak update (same edge as accept):
  - peak_ch <= max(peak_ch_d, mag), where peak_ch_d is the decayed value when a decay tick fires this cycle, otherwise the current peak.
  - The other channel holds, or takes the decay only.
- Decay:
  - The frame counter increments on each accepted right word and wraps at DECAY_FRAMES-1.
  - The wrapping accept is the decay tick: both peaks become peak - (peak >> 3), applied on the same edge.
  - For the right channel, the decay applies before the max with the incoming sample.
- LEDs are registered from the peak registers, so they lag the peak by one cycle:
  - led[0] = peak >= 0x000800
  - led[1] = peak >= 0x008000
  - led[2] = peak >= 0x080000
  - led[3] = peak >= 0x400000
  - Bars are thermometer-coded by construction.
- Clip:
  - An accepted sample with mag == 0x7FFFFF sets clip_ch=1 next cycle and reloads that channel's hold counter to CLIP_HOLD_FRAMES.
  - The hold counter decrements on each accepted right word (frame) while nonzero.
  - clip_ch clears on the cycle after the counter reaches 0.
  - Retrigger on the same edge as a decrement: the reload wins.
- Backpressure: peak, clip and frame logic advance only on accepted beats; stalled cycles change nothing.
- Reset mid-stream: the output register beat is discarded, peaks, LEDs and clip flags go to 0 immediately, and there is no partial-frame recovery (the next accepted beat is treated per its last bit).

Test Plan:
- Reset then 8 beats alternating last=0/1 with m_axis_ready=1 constantly -> m_axis_data/last match the inputs one cycle later; s_axis_ready stays 1; 8 outputs in 8 consecutive cycles.
- m_axis_ready held 0 for 5 cycles after a beat with data=0x123456 -> m_axis_valid=1, data stable at 0x123456, s_axis_ready=0; on release the next beat is accepted that cycle.
- Left sample 0x100000, right sample 0xFFF000 (-4096) -> peak_l=0x100000 and led_l=4'b0111; peak_r=0x001000 and led_r=4'b0001, both valid two cycles after their accepts.
- Left sample 0x800000 -> mag saturates to 0x7FFFFF, led_l=4'b1111 and clip_l=1; with CLIP_HOLD_FRAMES=4, clip_l clears after the 4th subsequent frame; a repeat clip at frame 3 extends the hold.
- DECAY_FRAMES=2, peak_l=0x400000, then silent frames -> after the 1st tick peak_l=0x380000 (led[3] drops), after the 2nd tick 0x310000; the right-channel tick beat with mag=0x390000 gives peak_r=max(decayed, 0x390000).
- axis_resetn pulsed low mid-frame with m_axis_valid=1 -> m_axis_valid, LEDs and clip flags are 0 asynchronously; s_axis_ready=0 during reset and 1 in the first cycle after release.
